// File: rtl/oven_setpoint_entry.sv
// Front-panel setpoint entry: synchronises the five buttons, runs the edit FSM,
// saturates the temperature/time setpoints and drives the four edit digits.
//
// state    | meaning
// ---------+------------------------------------------------
// IDLE     | waiting for Sel, display blank
// SET_TEMP | Up/Down edit inputTemp, Sel moves to SET_TIME
// SET_TIME | Up/Down edit timerVal, Sel back, Start to BAKE
// BAKE     | setpoints frozen, only Cancel honoured
module oven_setpoint_entry #(
    parameter int TEMP_MIN      = 150,
    parameter int TEMP_MAX      = 550,
    parameter int TEMP_STEP     = 25,
    parameter int TEMP_DEFAULT  = 350,
    parameter int TIME_MIN      = 30,
    parameter int TIME_MAX      = 990,
    parameter int TIME_STEP     = 30,
    parameter int TIME_DEFAULT  = 600,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnUp,
    input  logic       btnDown,
    input  logic       btnSel,
    input  logic       btnStart,
    input  logic       btnCancel,
    output logic [1:0] state,
    output logic [9:0] inputTemp,
    output logic [9:0] timerVal,
    output logic [3:0] editVal3,
    output logic [3:0] editVal2,
    output logic [3:0] editVal1,
    output logic [3:0] editVal0
);

    localparam int B_UP     = 0;
    localparam int B_DOWN   = 1;
    localparam int B_SEL    = 2;
    localparam int B_START  = 3;
    localparam int B_CANCEL = 4;
    localparam int TMR_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_TEMP = 2'd1,
        BAKE     = 2'd2,
        SET_TIME = 2'd3
    } state_t;

    state_t stateCur, stateNext;

    logic [4:0] btnRaw, sync1, sync2, prevLvl, armed, btnEdge, btnHeld;
    logic       primed1, primed2;
    logic       bothHigh, higherEv, inSet;
    logic       holdActive, holdDown, dirHeld, repeatFire;
    logic [TMR_W-1:0] repeatTmr;
    logic       stepUp, stepDown;
    logic [10:0] tempUp, tempDown, timeUp, timeDown;
    logic [9:0] tempNext, timeNext;
    logic [9:0] timeMin, timeSec;
    logic [15:0] digitNext;

    assign btnRaw = {btnCancel, btnStart, btnSel, btnDown, btnUp};

    // A button is armed only once it has been genuinely sampled low after reset,
    // so a button held through reset release never produces a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            prevLvl <= '0;
            armed   <= '0;
            primed1 <= 1'b0;
            primed2 <= 1'b0;
        end else begin
            sync1   <= btnRaw;
            sync2   <= sync1;
            prevLvl <= sync2;
            primed1 <= 1'b1;
            primed2 <= primed1;
            armed   <= armed | ({5{primed2}} & ~sync2);
        end
    end

    assign btnEdge  = sync2 & ~prevLvl & armed;
    assign btnHeld  = sync2 & armed;
    assign bothHigh = sync2[B_UP] & sync2[B_DOWN];
    assign higherEv = |btnEdge[B_CANCEL:B_SEL];
    assign inSet    = (stateCur == SET_TEMP) || (stateCur == SET_TIME);
    assign dirHeld  = holdDown ? btnHeld[B_DOWN] : btnHeld[B_UP];
    assign repeatFire = holdActive && (repeatTmr == '0) && dirHeld && !bothHigh;

    always_ff @(posedge clk) begin
        if (rst) stateCur <= IDLE;
        else     stateCur <= stateNext;
    end

    always_comb begin
        stateNext = stateCur;
        if (btnEdge[B_CANCEL]) begin
            stateNext = IDLE;
        end else if (btnEdge[B_START]) begin
            if (stateCur == SET_TIME) stateNext = BAKE;
        end else if (btnEdge[B_SEL]) begin
            case (stateCur)
                IDLE:     stateNext = SET_TEMP;
                SET_TEMP: stateNext = SET_TIME;
                SET_TIME: stateNext = SET_TEMP;
                default:  stateNext = stateCur;
            endcase
        end
    end

    assign tempUp   = {1'b0, inputTemp} + 11'(TEMP_STEP);
    assign tempDown = {1'b0, inputTemp} - 11'(TEMP_STEP);
    assign timeUp   = {1'b0, timerVal} + 11'(TIME_STEP);
    assign timeDown = {1'b0, timerVal} - 11'(TIME_STEP);
    assign timeMin  = timerVal / 10'd60;
    assign timeSec  = timerVal % 10'd60;

    always_comb begin
        stepUp    = !higherEv && ((btnEdge[B_UP] && !btnEdge[B_DOWN]) || (repeatFire && !holdDown));
        stepDown  = !higherEv && ((btnEdge[B_DOWN] && !btnEdge[B_UP]) || (repeatFire && holdDown));
        tempNext  = inputTemp;
        timeNext  = timerVal;
        digitNext = {4{4'd10}};
        if (stateCur == SET_TEMP) begin
            if (stepUp)
                tempNext = (tempUp > 11'(TEMP_MAX)) ? 10'(TEMP_MAX) : tempUp[9:0];
            else if (stepDown)
                tempNext = (tempDown[10] || tempDown < 11'(TEMP_MIN)) ? 10'(TEMP_MIN) : tempDown[9:0];
            digitNext = {4'd11, 4'(inputTemp / 10'd100), 4'((inputTemp / 10'd10) % 10'd10),
                         4'(inputTemp % 10'd10)};
        end else if (stateCur == SET_TIME) begin
            if (stepUp)
                timeNext = (timeUp > 11'(TIME_MAX)) ? 10'(TIME_MAX) : timeUp[9:0];
            else if (stepDown)
                timeNext = (timeDown[10] || timeDown < 11'(TIME_MIN)) ? 10'(TIME_MIN) : timeDown[9:0];
            digitNext = {4'(timeMin / 10'd10), 4'(timeMin % 10'd10),
                         4'(timeSec / 10'd10), 4'(timeSec % 10'd10)};
        end
    end

    // Repeat timer counts down from the press edge; terminal count issues a step.
    always_ff @(posedge clk) begin
        if (rst) begin
            holdActive <= 1'b0;
            holdDown   <= 1'b0;
            repeatTmr  <= '0;
        end else if (!inSet || stateNext != stateCur) begin
            holdActive <= 1'b0;
        end else if (btnEdge[B_UP] && !btnEdge[B_DOWN] && !bothHigh) begin
            holdActive <= 1'b1;
            holdDown   <= 1'b0;
            repeatTmr  <= TMR_W'(REPEAT_DELAY - 1);
        end else if (btnEdge[B_DOWN] && !btnEdge[B_UP] && !bothHigh) begin
            holdActive <= 1'b1;
            holdDown   <= 1'b1;
            repeatTmr  <= TMR_W'(REPEAT_DELAY - 1);
        end else if (holdActive && (!dirHeld || bothHigh)) begin
            holdActive <= 1'b0;
        end else if (holdActive) begin
            repeatTmr <= (repeatTmr == '0) ? TMR_W'(REPEAT_PERIOD - 1) : repeatTmr - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inputTemp <= 10'(TEMP_DEFAULT);
            timerVal  <= 10'(TIME_DEFAULT);
            {editVal3, editVal2, editVal1, editVal0} <= {4{4'd10}};
        end else begin
            inputTemp <= tempNext;
            timerVal  <= timeNext;
            {editVal3, editVal2, editVal1, editVal0} <= digitNext;
        end
    end

    assign state = stateCur;

endmodule

// File: tb/tb_oven_setpoint_entry.sv
// Randomised bench for oven_setpoint_entry: a pin-level reference model predicts
// every cycle's outputs into a queue that an independent monitor drains.
module tb_oven_setpoint_entry;

    localparam int UP = 0, DN = 1, SEL = 2, START = 3, CANCEL = 4;
    localparam int D = 8, P = 4;

    typedef struct packed {
        logic [1:0]  st;
        logic [9:0]  tp;
        logic [9:0]  tm;
        logic [15:0] dv;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] pins = '0;
    logic [1:0] state;
    logic [9:0] inputTemp, timerVal;
    logic [3:0] editVal3, editVal2, editVal1, editVal0;

    exp_t expQ[$];
    int nCompared = 0;
    int nMismatched = 0;

    oven_setpoint_entry #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
        .clk(clk), .rst(rst),
        .btnUp(pins[UP]), .btnDown(pins[DN]), .btnSel(pins[SEL]),
        .btnStart(pins[START]), .btnCancel(pins[CANCEL]),
        .state(state), .inputTemp(inputTemp), .timerVal(timerVal),
        .editVal3(editVal3), .editVal2(editVal2), .editVal1(editVal1), .editVal0(editVal0)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [4:0] hist[$];
    int  k;
    int  mState, mTemp, mTime;
    bit  armedM[5];
    bit  holdOn, holdDn;
    int  holdStart;

    function automatic logic [15:0] disp(int s, int t, int tm);
        if (s == 1) return {4'd11, 4'(t / 100), 4'((t / 10) % 10), 4'(t % 10)};
        if (s == 3) return {4'((tm / 60) / 10), 4'((tm / 60) % 10), 4'((tm % 60) / 10), 4'((tm % 60) % 10)};
        return 16'hAAAA;
    endfunction

    function automatic bit seen(int b, int j);
        if (j < 1 || j > hist.size()) return 1'b0;
        return hist[j-1][b];
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            hist.delete();
            k = 0; mState = 0; mTemp = 350; mTime = 600;
            holdOn = 0; holdDn = 0; holdStart = 0;
            for (int b = 0; b < 5; b++) armedM[b] = 0;
            e = '{st: 2'd0, tp: 10'd350, tm: 10'd600, dv: 16'hAAAA};
        end else begin
            bit lvl[5], ev[5], held[5];
            bit inSet, both, fire, higher, dirHeld, up, dn;
            int newState, c;
            k++;
            hist.push_back(pins);
            for (int b = 0; b < 5; b++) begin
                if (k - 3 >= 1 && !seen(b, k - 3)) armedM[b] = 1;
                lvl[b]  = seen(b, k - 2);
                ev[b]   = (k >= 4) && seen(b, k - 2) && !seen(b, k - 3);
                held[b] = lvl[b] && armedM[b];
            end
            e.dv  = disp(mState, mTemp, mTime);
            inSet = (mState == 1) || (mState == 3);
            both  = lvl[UP] && lvl[DN];
            dirHeld = holdDn ? held[DN] : held[UP];
            c = k - holdStart;
            fire = holdOn && dirHeld && !both && (c == D || (c > D && (c - D) % P == 0));
            higher = ev[CANCEL] || ev[START] || ev[SEL];
            newState = mState;
            if (ev[CANCEL]) newState = 0;
            else if (ev[START]) begin if (mState == 3) newState = 2; end
            else if (ev[SEL]) begin
                if (mState == 0) newState = 1;
                else if (mState == 1) newState = 3;
                else if (mState == 3) newState = 1;
            end
            up = !higher && ((ev[UP] && !ev[DN]) || (fire && !holdDn));
            dn = !higher && ((ev[DN] && !ev[UP]) || (fire && holdDn));
            if (mState == 1) begin
                if (up) mTemp = (mTemp + 25 > 550) ? 550 : mTemp + 25;
                else if (dn) mTemp = (mTemp - 25 < 150) ? 150 : mTemp - 25;
            end else if (mState == 3) begin
                if (up) mTime = (mTime + 30 > 990) ? 990 : mTime + 30;
                else if (dn) mTime = (mTime - 30 < 30) ? 30 : mTime - 30;
            end
            if (!inSet || newState != mState) holdOn = 0;
            else if (ev[UP] && !ev[DN] && !both) begin holdOn = 1; holdDn = 0; holdStart = k; end
            else if (ev[DN] && !ev[UP] && !both) begin holdOn = 1; holdDn = 1; holdStart = k; end
            else if (holdOn && (!dirHeld || both)) holdOn = 0;
            mState = newState;
            e.st = 2'(mState);
            e.tp = 10'(mTemp);
            e.tm = 10'(mTime);
        end
        expQ.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            nCompared++;
            if (state !== e.st) begin
                nMismatched++;
                $display("FAIL state @%0t: got %0d want %0d", $time, state, e.st);
            end
            nCompared++;
            if (inputTemp !== e.tp || timerVal !== e.tm) begin
                nMismatched++;
                $display("FAIL setpoints @%0t: got temp=%0d time=%0d want temp=%0d time=%0d",
                         $time, inputTemp, timerVal, e.tp, e.tm);
            end
            nCompared++;
            if ({editVal3, editVal2, editVal1, editVal0} !== e.dv) begin
                nMismatched++;
                $display("FAIL editVal @%0t: got %h want %h", $time,
                         {editVal3, editVal2, editVal1, editVal0}, e.dv);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(int b, int len);
        pins[b] = 1'b1;
        cyc(len);
        pins[b] = 1'b0;
        cyc(4);
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(5);
        // Sel, Up, Up, Down
        press(SEL, 1); press(UP, 1); press(UP, 1); press(DN, 1);
        cyc(3);
        // SET_TIME, walk to 960, then hold Up into saturation
        press(SEL, 1); press(SEL, 1); press(SEL, 1);
        repeat (12) press(UP, 1);
        pins[UP] = 1'b1; cyc(30); pins[UP] = 1'b0; cyc(4);
        // Start and Up together, then ignored buttons in BAKE
        pins[START] = 1'b1; pins[UP] = 1'b1; cyc(1); pins = '0; cyc(4);
        press(UP, 1); press(DN, 1); press(SEL, 1);
        press(CANCEL, 1);
        // Up held through reset release
        press(SEL, 1);
        pins[UP] = 1'b1; cyc(2); rst = 1'b1; cyc(2); rst = 1'b0; cyc(5);
        press(SEL, 1); cyc(10);
        pins[UP] = 1'b0; cyc(3);
        press(UP, 1);
        // hold Down through several repeat steps
        pins[DN] = 1'b1; cyc(40); pins[DN] = 1'b0; cyc(4);
        // randomised segments
        repeat (160) begin
            int r, len;
            r = $urandom_range(0, 99);
            len = $urandom_range(1, 3);
            if (r < 38) begin
                pins[$urandom_range(UP, DN)] = 1'b1; cyc(len); pins = '0;
            end else if (r < 55) begin
                pins[$urandom_range(UP, DN)] = 1'b1;
                if ($urandom_range(0, 7) == 0) pins[$urandom_range(UP, DN)] = 1'b1;
                cyc($urandom_range(5, 40)); pins = '0;
            end else if (r < 70) begin
                pins[SEL] = 1'b1; cyc(len); pins = '0;
            end else if (r < 76) begin
                pins[START] = 1'b1; cyc(len); pins = '0;
            end else if (r < 80) begin
                pins[CANCEL] = 1'b1; cyc(len); pins = '0;
            end else if (r < 83) begin
                rst = 1'b1; cyc(len); rst = 1'b0;
            end else if (r < 92) begin
                repeat (len) begin pins = 5'($urandom_range(0, 31)); cyc(1); end
                pins = '0;
            end
            cyc($urandom_range(0, 4));
        end
        pins = '0;
        cyc(6);
        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", nCompared);
        $fatal(1, "watchdog");
    end

endmodule
